mole_scheduler: RTL and testbench

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

---
 rtl/wam_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 34 +++
 rtl/mole_scheduler.sv | 148 ++++++++++++++
 tb/tb_mole_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wam_pkg.sv
// Shared whack-a-mole types and widths: FSM state encoding and bus widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package wam_pkg;

  localparam int NUM_HOLES = 8;
  localparam int HOLE_W    = 3;
  localparam int SCORE_W   = 8;
  localparam int MISS_W    = 4;
  localparam int TICKCNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_UP,
    ST_GAP,
    ST_OVER
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Game-tick prescaler: one-cycle tick every TICK_CYCLES clk cycles, restartable.
// Latency: first tick TICK_CYCLES cycles after the last cycle clear was high.
// Backpressure: none; free-running counter, clear has priority.
// Ports: clk, reset (async active-low), clear (restart count at 0), tick (pulse).
module tick_prescaler #(
  parameter int TICK_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

  // Tick is not gated by clear: the scheduler's next-state logic reads tick
  // and also produces clear, so gating here would close a combinational loop.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: picks a hole, shows the mole, scores hits and timeouts.
// Latency: mole appears 1 cycle after PICK; score/misses update 1 cycle after hit/timeout.
// Backpressure: none; rnd is always valid, hit/start are single-cycle pulses.
// Ports: clk, reset (async active-low), rnd[15:0], start, hit[7:0] in;
//        mole[7:0] (one-hot), score[7:0], misses[3:0], game_over out.
module mole_scheduler
  import wam_pkg::*;
#(
  parameter int TICK_CYCLES  = 500000,
  parameter int UP_MIN_TICKS = 50,
  parameter int GAP_TICKS    = 20,
  parameter int MAX_MISSES   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          rnd,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] hit,
  output logic [NUM_HOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic [MISS_W-1:0]    misses,
  output logic                 game_over
);

  localparam logic [TICKCNT_W-1:0] UP_MIN_L = TICKCNT_W'(UP_MIN_TICKS);
  localparam logic [TICKCNT_W-1:0] GAP_L    = TICKCNT_W'(GAP_TICKS);
  localparam logic [MISS_W-1:0]    MAX_L    = MISS_W'(MAX_MISSES);

  state_t                 state, state_nxt;
  logic [HOLE_W-1:0]      last_hole;   // doubles as the active hole while UP
  logic [HOLE_W-1:0]      pick_hole;
  logic                   first_pick;
  logic [TICKCNT_W-1:0]   up_limit, pick_limit, tick_cnt;
  logic [3:0]             level;
  logic [MISS_W-1:0]      misses_inc;
  logic                   tick, clear;
  logic                   start_ok, hit_now, timeout_now, gap_done;
  logic                   unused_rnd;

  assign unused_rnd = ^rnd[15:8];

  tick_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  // Hole selection: avoid showing the same hole twice in a row within a game.
  always_comb begin
    pick_hole = rnd[2:0];
    if (!first_pick && (rnd[2:0] == last_hole)) begin
      pick_hole = rnd[2:0] + 3'd1;
    end
  end

  // Difficulty: every 8 points shortens the up time by one tick, capped at 15.
  assign level      = score[7] ? 4'd15 : score[6:3];
  assign pick_limit = UP_MIN_L + {3'b000, rnd[7:3]} - {4'b0000, level};
  assign misses_inc = misses + 4'd1;

  assign start_ok    = ((state == ST_IDLE) || (state == ST_OVER)) && start;
  assign hit_now     = (state == ST_UP) && hit[last_hole];
  assign timeout_now = (state == ST_UP) && tick && (tick_cnt == up_limit - 8'd1);
  assign gap_done    = (state == ST_GAP) && tick && (tick_cnt == GAP_L - 8'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mole      = '0;
    game_over = 1'b0;
    // Prescaler and tick count sit at 0 outside UP/GAP and restart on any
    // transition, so each UP/GAP dwell begins with a fresh full tick period.
    clear     = 1'b1;
    unique case (state)
      ST_IDLE, ST_OVER: begin
        game_over = (state == ST_OVER);
        if (start) state_nxt = ST_PICK;
      end
      ST_PICK: begin
        state_nxt = ST_UP;
      end
      ST_UP: begin
        mole = {{(NUM_HOLES-1){1'b0}}, 1'b1} << last_hole;
        // A hit on the timeout cycle wins over the timeout.
        if (hit_now) begin
          state_nxt = ST_GAP;
        end else if (timeout_now) begin
          state_nxt = (misses_inc == MAX_L) ? ST_OVER : ST_GAP;
        end
        clear = (state_nxt != state);
      end
      ST_GAP: begin
        if (gap_done) state_nxt = ST_PICK;
        clear = (state_nxt != state);
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (clear) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score      <= '0;
      misses     <= '0;
      last_hole  <= '0;
      up_limit   <= '0;
      first_pick <= 1'b1;
    end else begin
      if (start_ok) begin
        score      <= '0;
        misses     <= '0;
        first_pick <= 1'b1;
      end
      if (state == ST_PICK) begin
        last_hole  <= pick_hole;
        up_limit   <= pick_limit;
        first_pick <= 1'b0;
      end
      if (hit_now) begin
        if (score != 8'hFF) score <= score + 8'd1;
      end else if (timeout_now) begin
        misses <= misses_inc;
      end
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Testbench for mole_scheduler: randomized games against an event-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mole_scheduler;

  localparam int T    = 4;
  localparam int UPM  = 16;
  localparam int G    = 2;
  localparam int MAXM = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] rnd = 16'h0;
  logic [7:0]  hit = 8'h0;
  logic [7:0]  mole;
  logic [7:0]  score;
  logic [3:0]  misses;
  logic        game_over;

  mole_scheduler #(
    .TICK_CYCLES (T),
    .UP_MIN_TICKS(UPM),
    .GAP_TICKS   (G),
    .MAX_MISSES  (MAXM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rnd      (rnd),
    .start    (start),
    .hit      (hit),
    .mole     (mole),
    .score    (score),
    .misses   (misses),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] mole;
    logic [7:0] score;
    logic [3:0] misses;
    logic       go;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  bit  in_reset = 1'b1;

  // Game-level model state.
  int m_score, m_misses, m_last;
  bit m_first, m_done;
  // Last output tuple the model has predicted.
  logic [7:0] e_mole = 8'h0, e_score = 8'h0;
  logic [3:0] e_miss = 4'h0;
  logic       e_go = 1'b0;

  task automatic check(input bit ok, input string name, input string act, input string exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, act, exp);
  endtask

  task automatic push_ev(input int c, input logic [7:0] mo, input int sc, input int mi, input bit go);
    ev_t e;
    if (mo == e_mole && 8'(sc) == e_score && 4'(mi) == e_miss && go == e_go) return;
    e.cyc = c; e.mole = mo; e.score = 8'(sc); e.misses = 4'(mi); e.go = go;
    exp_q.push_back(e);
    e_mole = mo; e_score = 8'(sc); e_miss = 4'(mi); e_go = go;
  endtask

  // Monitor: every output change must match the next predicted event, on its cycle.
  logic [20:0] prev_t = '0;
  always @(negedge clk) begin
    logic [20:0] cur;
    ev_t e;
    cur = {mole, score, misses, game_over};
    if (in_reset) begin
      prev_t = cur;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check(1'b0, "missed_event", $sformatf("no change by cyc %0d", cyc),
              $sformatf("cyc=%0d mole=%h score=%0d misses=%0d over=%0b",
                        e.cyc, e.mole, e.score, e.misses, e.go));
      end
      if (cur !== prev_t) begin
        prev_t = cur;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_change",
                $sformatf("cyc=%0d mole=%h score=%0d misses=%0d over=%0b",
                          cyc, mole, score, misses, game_over), "no change");
        end else begin
          e = exp_q.pop_front();
          check(cyc == e.cyc && cur === {e.mole, e.score, e.misses, e.go}, "output_event",
                $sformatf("cyc=%0d mole=%h score=%0d misses=%0d over=%0b",
                          cyc, mole, score, misses, game_over),
                $sformatf("cyc=%0d mole=%h score=%0d misses=%0d over=%0b",
                          e.cyc, e.mole, e.score, e.misses, e.go));
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic noise_inputs(input logic [7:0] mask, input bit allow_start);
    rnd   = 16'($urandom);
    hit   = ($urandom_range(0, 3) == 0) ? (8'($urandom) & mask) : 8'h00;
    start = allow_start && ($urandom_range(0, 7) == 0);
  endtask

  task automatic outputs_zero(input string name);
    check(mole == 8'h0 && score == 8'h0 && misses == 4'h0 && game_over == 1'b0, name,
          $sformatf("mole=%h score=%0d misses=%0d over=%0b", mole, score, misses, game_over),
          "all zero");
  endtask

  // Leaves the driver on the PICK cycle.
  task automatic start_game();
    next_cycle();
    noise_inputs(8'hFF, 1'b0);
    start = 1'b1;
    m_score = 0; m_misses = 0; m_first = 1'b1; m_done = 1'b0;
    push_ev(cyc + 1, 8'h00, 0, 0, 1'b0);
    next_cycle();
    noise_inputs(8'hFF, 1'b1);
  endtask

  task automatic reset_abort();
    #2;
    reset = 1'b0;
    in_reset = 1'b1;
    #1;
    outputs_zero("reset_async_clear");
    exp_q.delete();
    m_score = 0; m_misses = 0; m_last = 0; m_first = 1'b1; m_done = 1'b1;
    e_mole = 8'h0; e_score = 8'h0; e_miss = 4'h0; e_go = 1'b0;
    hit = 8'h0; start = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b1;
    in_reset = 1'b0;
    repeat (20) begin
      next_cycle();
      noise_inputs(8'hFF, 1'b0);
    end
    outputs_zero("idle_waits_after_reset");
  endtask

  // Called on the PICK cycle. mode 0: timeout; 1: hit at offset k (k<0 = last
  // UP cycle); 2: hit at a random offset. abort_j >= 0 resets mid-UP.
  task automatic do_mole(input logic [15:0] r, input int mode, input int k, input int abort_j);
    int hole, lvl, lim, kk;
    logic [7:0] hmask;
    rnd = r;
    hole = int'(r[2:0]);
    if (!m_first && hole == m_last) hole = (hole + 1) % 8;
    m_last = hole;
    m_first = 1'b0;
    lvl = m_score / 8;
    if (lvl > 15) lvl = 15;
    lim = (UPM + int'(r[7:3]) - lvl) * T;
    if (mode == 0) kk = -1;
    else if (mode == 2) kk = $urandom_range(0, lim - 1);
    else kk = (k < 0 || k > lim - 1) ? lim - 1 : k;
    push_ev(cyc + 1, 8'(1 << hole), m_score, m_misses, 1'b0);
    hmask = ~(8'h01 << hole);
    for (int j = 0; j < lim; j++) begin
      next_cycle();
      noise_inputs(hmask, 1'b1);
      if (j == 0) hit = (8'h01 | 8'($urandom)) & hmask;
      if (j == abort_j) begin
        reset_abort();
        return;
      end
      if (j == kk) begin
        hit[hole] = 1'b1;
        if (m_score < 255) m_score++;
        push_ev(cyc + 1, 8'h00, m_score, m_misses, 1'b0);
        break;
      end
      if (j == lim - 1) begin
        m_misses++;
        m_done = (m_misses == MAXM);
        push_ev(cyc + 1, 8'h00, m_score, m_misses, m_done);
      end
    end
    if (m_done) return;
    for (int j = 0; j < G * T; j++) begin
      next_cycle();
      noise_inputs(8'hFF, 1'b1);
    end
    next_cycle();
    noise_inputs(8'hFF, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      next_cycle();
      noise_inputs(8'hFF, 1'b0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) next_cycle();
    outputs_zero("reset_state");
    reset = 1'b1;
    in_reset = 1'b0;
    idle_cycles(5);
    outputs_zero("idle_before_start");

    // Game 1: directed opening, then random until game over.
    start_game();
    do_mole(16'h0015, 0, 0, -1);   // hole 5, 18 ticks, timeout
    do_mole(16'h0015, 1, -1, -1);  // repeat avoided -> hole 6, hit on timeout cycle
    do_mole(16'h0015, 1, 7, -1);   // hole 5, hit after a wrong-hole pulse
    while (!m_done) do_mole(16'($urandom), $urandom_range(0, 2), 0, -1);
    idle_cycles(6);

    // Game 2: restart from OVER, fast hits past score saturation, then timeouts.
    start_game();
    for (int i = 0; i < 270 && !m_done; i++)
      do_mole(16'($urandom), 1, $urandom_range(0, 3), -1);
    while (!m_done) do_mole(16'($urandom), ($urandom_range(0, 1) == 0) ? 0 : 2, 0, -1);
    idle_cycles(6);

    // Game 3: a few hits, then reset in the middle of UP.
    start_game();
    for (int i = 0; i < 4; i++) do_mole(16'($urandom), 1, $urandom_range(0, 5), -1);
    do_mole(16'($urandom), 0, 0, $urandom_range(1, 10));

    // Game 4: random play from IDLE.
    start_game();
    while (!m_done) do_mole(16'($urandom), ($urandom_range(0, 3) == 0) ? 0 : 2, 0, -1);
    idle_cycles(10);

    check(exp_q.size() == 0, "events_drained",
          $sformatf("%0d pending", exp_q.size()), "0 pending");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
